// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan driver: one shared active-low cathode bus, per-digit
// active-low anodes, ghost blanking, leading-zero blanking and frame-aligned value updates.
module seg_scan_mux #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  lzb_i,
  input  logic                  load_i,
  output logic [N_DIGITS-1:0]   anode_o,
  output logic [7:0]            cathode_o,
  output logic                  frame_start_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DW-1:0]       stage_dig_q, stage_dig_d, shad_dig_q, shad_dig_d;
  logic [N_DIGITS-1:0] stage_dp_q, stage_dp_d, shad_dp_q, shad_dp_d;
  logic [N_DIGITS-1:0] stage_en_q, stage_en_d, shad_en_q, shad_en_d;
  logic                pending_q, pending_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                fs_q, fs_d;

  logic       wrap, last, commit;
  logic [3:0] nib;
  logic       dp_sel, en_sel, upper_nz, lz_blank, ghost;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    wrap   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    last   = (idx_q == IDX_W'(N_DIGITS - 1));
    commit = wrap && last && pending_q;

    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (wrap) idx_d = last ? '0 : idx_q + IDX_W'(1);

    // A load coinciding with the commit edge lands in staging only and waits a frame.
    stage_dig_d = load_i ? digits_i   : stage_dig_q;
    stage_dp_d  = load_i ? dp_i       : stage_dp_q;
    stage_en_d  = load_i ? digit_en_i : stage_en_q;
    pending_d   = load_i ? 1'b1 : (commit ? 1'b0 : pending_q);

    shad_dig_d = commit ? stage_dig_q : shad_dig_q;
    shad_dp_d  = commit ? stage_dp_q  : shad_dp_q;
    shad_en_d  = commit ? stage_en_q  : shad_en_q;
  end

  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    en_sel   = 1'b0;
    upper_nz = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        nib    = shad_dig_q[4*i +: 4];
        dp_sel = shad_dp_q[i];
        en_sel = shad_en_q[i];
      end
      if (i >= int'(idx_q) && shad_dig_q[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    lz_blank = lzb_i && (idx_q != '0) && !upper_nz;
    ghost    = (cnt_q < CNT_W'(BLANK_CYCLES));

    anode_d   = '1;
    cathode_d = 8'hFF;
    if (!ghost && en_sel && !lz_blank) begin
      anode_d   = ~(N_DIGITS'(1) << idx_q);
      cathode_d = {~dp_sel, seg7(nib)};
    end
    fs_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_dig_q <= '0;
      stage_dp_q  <= '0;
      stage_en_q  <= '0;
      pending_q   <= 1'b0;
      shad_dig_q  <= '0;
      shad_dp_q   <= '0;
      shad_en_q   <= '1;
      anode_q     <= '1;
      cathode_q   <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_dig_q <= stage_dig_d;
      stage_dp_q  <= stage_dp_d;
      stage_en_q  <= stage_en_d;
      pending_q   <= pending_d;
      shad_dig_q  <= shad_dig_d;
      shad_dp_q   <= shad_dp_d;
      shad_en_q   <= shad_en_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      fs_q        <= fs_d;
    end
  end

  assign anode_o       = anode_q;
  assign cathode_o     = cathode_q;
  assign frame_start_o = fs_q;

endmodule
